// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I fields into an ALU op, selects operands and buffers them into EX
// through a two-entry skid buffer. Define ALU_ISSUE_STRICT_DECODE_EN to reject non-canonical funct7.
module alu_issue_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic            is_branch,
  output logic            br_on_zero,
  output logic            illegal
);

  localparam logic [3:0] OpAdd     = 4'b0000;
  localparam logic [3:0] OpSub     = 4'b0001;
  localparam logic [3:0] OpAnd     = 4'b0010;
  localparam logic [3:0] OpOr      = 4'b0011;
  localparam logic [3:0] OpXor     = 4'b0100;
  localparam logic [3:0] OpUHighEq = 4'b0111;
  localparam logic [3:0] OpSHighEq = 4'b1000;
  localparam logic [3:0] OpULower  = 4'b1001;
  localparam logic [3:0] OpSLower  = 4'b1010;
  localparam logic [3:0] OpSll     = 4'b1101;
  localparam logic [3:0] OpSrl     = 4'b1110;
  localparam logic [3:0] OpSra     = 4'b1111;

  localparam logic [6:0] OpcOp     = 7'b0110011;
  localparam logic [6:0] OpcOpImm  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcLui    = 7'b0110111;
  localparam logic [6:0] OpcAuipc  = 7'b0010111;
  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [1:0] StEmpty = 2'd0;
  localparam logic [1:0] StOne   = 2'd1;
  localparam logic [1:0] StFull  = 2'd2;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] in1;
    logic [XLEN-1:0] in2;
    logic            br;
    logic            boz;
    logic            ill;
  } entry_t;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [XLEN-1:0] rs2_shamt;
  logic [XLEN-1:0] imm_shamt;
  logic            unused_instr;
  entry_t          dec;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign alt       = instr[30];
  assign rs2_shamt = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
  assign imm_shamt = {{(XLEN-5){1'b0}}, imm[4:0]};
  assign unused_instr = ^instr[31:7];

  always_comb begin
    dec = '0;
    case (opcode)
      OpcOp, OpcOpImm: begin
        dec.in1 = rs1_data;
        dec.in2 = (opcode == OpcOp) ? rs2_data : imm;
        case (funct3)
          3'b000: dec.op = (alt && opcode == OpcOp) ? OpSub : OpAdd;
          3'b001: begin
            dec.op  = OpSll;
            dec.in2 = (opcode == OpcOp) ? rs2_shamt : imm_shamt;
          end
          3'b010: dec.op = OpSLower;
          3'b011: dec.op = OpULower;
          3'b100: dec.op = OpXor;
          3'b101: begin
            dec.op  = alt ? OpSra : OpSrl;
            dec.in2 = (opcode == OpcOp) ? rs2_shamt : imm_shamt;
          end
          3'b110: dec.op = OpOr;
          default: dec.op = OpAnd;
        endcase
`ifdef ALU_ISSUE_STRICT_DECODE_EN
        if (opcode == OpcOp) begin
          if (!(instr[31:25] == 7'b0000000 ||
                (instr[31:25] == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))) begin
            dec.ill = 1'b1;
          end
        end else if (funct3 == 3'b001) begin
          if (instr[31:25] != 7'b0000000) dec.ill = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (instr[31:25] != 7'b0000000 && instr[31:25] != 7'b0100000) dec.ill = 1'b1;
        end
`endif
      end
      OpcLoad, OpcStore: begin
        dec.in1 = rs1_data;
        dec.in2 = imm;
      end
      OpcLui: dec.in2 = imm;
      OpcAuipc: begin
        dec.in1 = pc;
        dec.in2 = imm;
      end
      OpcJal, OpcJalr: begin
        dec.in1 = pc;
        dec.in2 = XLEN'(4);
      end
      OpcBranch: begin
        dec.in1 = rs1_data;
        dec.in2 = rs2_data;
        dec.br  = 1'b1;
        case (funct3)
          3'b000: begin
            dec.op  = OpSub;
            dec.boz = 1'b1;
          end
          3'b001: dec.op = OpSub;
          3'b100: dec.op = OpSLower;
          3'b101: dec.op = OpSHighEq;
          3'b110: dec.op = OpULower;
          3'b111: dec.op = OpUHighEq;
          default: dec.ill = 1'b1;
        endcase
      end
      default: dec.ill = 1'b1;
    endcase
    // Illegal encodings always issue as a harmless ADD of zeros.
    if (dec.ill) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
  end

  logic [1:0] state_q, state_d;
  entry_t     main_q, main_d, skid_q;
  logic       main_we, skid_we;
  logic       accept, drain;

  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q != StEmpty);
  assign accept    = in_valid && in_ready;
  assign drain     = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = dec;
    main_we = 1'b0;
    skid_we = 1'b0;
    case (state_q)
      StEmpty: begin
        if (accept) begin
          state_d = StOne;
          main_we = 1'b1;
        end
      end
      StOne: begin
        if (accept && drain) begin
          main_we = 1'b1;
        end else if (accept) begin
          state_d = StFull;
          skid_we = 1'b1;
        end else if (drain) begin
          state_d = StEmpty;
        end
      end
      StFull: begin
        if (drain) begin
          state_d = StOne;
          main_d  = skid_q;
          main_we = 1'b1;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else if (flush) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
      if (main_we) main_q <= main_d;
      if (skid_we) skid_q <= dec;
    end
  end

  assign alu_op     = main_q.op;
  assign alu_in1    = main_q.in1;
  assign alu_in2    = main_q.in2;
  assign is_branch  = main_q.br;
  assign br_on_zero = main_q.boz;
  assign illegal    = main_q.ill;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed spec vectors plus randomized traffic against a
// queue-based reference model. Honours ALU_ISSUE_STRICT_DECODE_EN like the design.
module tb_alu_issue_stage;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND = 4'h2, OR = 4'h3, XOR = 4'h4;
  localparam logic [3:0] UHE = 4'h7, SHE = 4'h8, ULO = 4'h9, SLO = 4'hA;
  localparam logic [3:0] SLL = 4'hD, SRL = 4'hE, SRA = 4'hF;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        br;
    logic        boz;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic [31:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  alu_op;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        is_branch;
  logic        br_on_zero;
  logic        illegal;
  exp_t        got;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];

  alu_issue_stage #(.XLEN(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .imm        (imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_op     (alu_op),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .is_branch  (is_branch),
    .br_on_zero (br_on_zero),
    .illegal    (illegal)
  );

  assign got = {alu_op, alu_in1, alu_in2, is_branch, br_on_zero, illegal};

  always #5 clk = ~clk;

  // Reference decode: instruction class -> mnemonic op and operands.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pcv,
                                      input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] im);
    exp_t e;
    logic [3:0] base [8];
    logic [3:0] brop [8];
    int f3;
    bit ok;
    base = '{ADD, SLL, SLO, ULO, XOR, SRL, OR, AND};
    brop = '{SUB, SUB, ADD, ADD, SLO, SHE, ULO, UHE};
    f3 = int'(ins[14:12]);
    e = '{op: ADD, in1: 0, in2: 0, br: 0, boz: 0, ill: 1};
    case (ins[6:0])
      7'h33: begin
        ok = 1;
`ifdef ALU_ISSUE_STRICT_DECODE_EN
        ok = (ins[31:25] == 0) || (ins[31:25] == 7'h20 && (f3 == 0 || f3 == 5));
`endif
        if (ok) begin
          e = '{op: base[f3], in1: a, in2: b, br: 0, boz: 0, ill: 0};
          if (ins[30] && f3 == 0) e.op = SUB;
          if (ins[30] && f3 == 5) e.op = SRA;
          if (f3 == 1 || f3 == 5) e.in2 = b % 32;
        end
      end
      7'h13: begin
        ok = 1;
`ifdef ALU_ISSUE_STRICT_DECODE_EN
        if (f3 == 1) ok = (ins[31:25] == 0);
        if (f3 == 5) ok = (ins[31:25] == 0) || (ins[31:25] == 7'h20);
`endif
        if (ok) begin
          e = '{op: base[f3], in1: a, in2: im, br: 0, boz: 0, ill: 0};
          if (ins[30] && f3 == 5) e.op = SRA;
          if (f3 == 1 || f3 == 5) e.in2 = im % 32;
        end
      end
      7'h03, 7'h23: e = '{op: ADD, in1: a, in2: im, br: 0, boz: 0, ill: 0};
      7'h37:        e = '{op: ADD, in1: 0, in2: im, br: 0, boz: 0, ill: 0};
      7'h17:        e = '{op: ADD, in1: pcv, in2: im, br: 0, boz: 0, ill: 0};
      7'h6f, 7'h67: e = '{op: ADD, in1: pcv, in2: 4, br: 0, boz: 0, ill: 0};
      7'h63: begin
        if (f3 != 2 && f3 != 3)
          e = '{op: brop[f3], in1: a, in2: b, br: 1, boz: (f3 == 0), ill: 0};
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [6:0] opcs [9];
    int k;
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6f, 7'h67, 7'h63};
    r = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) r[6:0] = opcs[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  // Apply one cycle of inputs and advance the reference buffer model across the edge.
  task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, input logic fl,
                       input logic rs, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im);
    exp_t e;
    bit acc, drn;
    in_valid = v; instr = ins; out_ready = ordy; flush = fl; rst = rs;
    pc = $urandom; rs1_data = a; rs2_data = b; imm = im;
    e = ref_decode(ins, pc, a, b, im);
    acc = v && (q.size() < 2);
    drn = ordy && (q.size() > 0);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 32'h002081B3, 0, 0, 0, 9, 9, 9);
    drive(1, 32'h002081B3, 0, 0, 0, 9, 9, 9);
    drive(1, 32'h00208463, 0, 1, 1, 3, 4, 5);
    vectors++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_handshake: got out_valid=%b in_ready=%b expected 0/1",
               out_valid, in_ready);
    end
    vectors++;
    if (got !== exp_t'(0)) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected all zero", got);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [31:0] r;
    r = $urandom;
    drive(1, 32'h002081B3, 1, 0, 0, 5, 7, r);
    vectors++;
    if (out_valid !== 1 || alu_op !== ADD || alu_in1 !== 5 || alu_in2 !== 7 || illegal !== 0) begin
      miscompares++;
      $display("FAIL add: got v=%b op=%h in1=%h in2=%h ill=%b expected 1/0/5/7/0",
               out_valid, alu_op, alu_in1, alu_in2, illegal);
    end
    drive(1, 32'h402081B3, 1, 0, 0, 10, 3, r);
    vectors++;
    if (alu_op !== SUB || alu_in1 !== 10 || alu_in2 !== 3) begin
      miscompares++;
      $display("FAIL sub: got op=%h in1=%h in2=%h expected 1/a/3", alu_op, alu_in1, alu_in2);
    end
    drive(1, 32'h40335293, 1, 0, 0, 32'h8000_0000, 32'hffff_ffff, 32'h403);
    vectors++;
    if (alu_op !== SRA || alu_in1 !== 32'h8000_0000 || alu_in2 !== 3 || illegal !== 0) begin
      miscompares++;
      $display("FAIL srai: got op=%h in1=%h in2=%h ill=%b expected f/80000000/3/0",
               alu_op, alu_in1, alu_in2, illegal);
    end
    drive(1, 32'h00208463, 1, 0, 0, 21, 21, r);
    vectors++;
    if (alu_op !== SUB || is_branch !== 1 || br_on_zero !== 1 || alu_in1 !== 21) begin
      miscompares++;
      $display("FAIL beq: got op=%h br=%b boz=%b in1=%h expected 1/1/1/15",
               alu_op, is_branch, br_on_zero, alu_in1);
    end
    drive(1, 32'h0020A463, 1, 0, 0, 21, 22, r);
    vectors++;
    if (illegal !== 1 || alu_op !== ADD || alu_in1 !== 0 || alu_in2 !== 0 || is_branch !== 0) begin
      miscompares++;
      $display("FAIL br_f3_010: got ill=%b op=%h in1=%h in2=%h br=%b expected 1/0/0/0/0",
               illegal, alu_op, alu_in1, alu_in2, is_branch);
    end
    drive(1, 32'h02208033, 1, 0, 0, 6, 8, r);
    vectors++;
`ifdef ALU_ISSUE_STRICT_DECODE_EN
    if (illegal !== 1 || alu_op !== ADD || alu_in1 !== 0) begin
      miscompares++;
      $display("FAIL funct7_01: got ill=%b op=%h in1=%h expected 1/0/0", illegal, alu_op, alu_in1);
    end
`else
    if (illegal !== 0 || alu_op !== ADD || alu_in1 !== 6 || alu_in2 !== 8) begin
      miscompares++;
      $display("FAIL funct7_01: got ill=%b op=%h in1=%h in2=%h expected 0/0/6/8",
               illegal, alu_op, alu_in1, alu_in2);
    end
`endif
    drive(1, 32'h123450EF, 1, 0, 0, 1, 2, r);
    vectors++;
    if (alu_op !== ADD || alu_in1 !== pc || alu_in2 !== 4) begin
      miscompares++;
      $display("FAIL jal: got op=%h in1=%h in2=%h expected 0/%h/4", alu_op, alu_in1, alu_in2, pc);
    end
    drive(0, 32'h0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (out_valid !== 0) begin
      miscompares++;
      $display("FAIL drain_idle: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 32'h002081B3, 0, 0, 0, 1, 0, 0);
    drive(1, 32'h002081B3, 0, 0, 0, 2, 0, 0);
    vectors++;
    if (in_ready !== 0 || out_valid !== 1 || alu_in1 !== 1) begin
      miscompares++;
      $display("FAIL b2b_full: got in_ready=%b v=%b in1=%h expected 0/1/1",
               in_ready, out_valid, alu_in1);
    end
    drive(1, 32'h002081B3, 0, 0, 0, 3, 0, 0);
    vectors++;
    if (in_ready !== 0 || alu_in1 !== 1) begin
      miscompares++;
      $display("FAIL b2b_stall: got in_ready=%b in1=%h expected 0/1", in_ready, alu_in1);
    end
    drive(0, 32'h0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (out_valid !== 1 || in_ready !== 1 || alu_in1 !== 2) begin
      miscompares++;
      $display("FAIL b2b_second: got v=%b in_ready=%b in1=%h expected 1/1/2",
               out_valid, in_ready, alu_in1);
    end
    drive(0, 32'h0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (out_valid !== 0) begin
      miscompares++;
      $display("FAIL b2b_dropped: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    drive(1, 32'h002081B3, 0, 0, 0, 1, 1, 1);
    drive(1, 32'h002081B3, 0, 0, 0, 2, 2, 2);
    drive(1, 32'h002081B3, 0, 1, 0, 3, 3, 3);
    vectors++;
    if (out_valid !== 0 || in_ready !== 1) begin
      miscompares++;
      $display("FAIL flush: got v=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
    drive(0, 32'h0, 1, 0, 0, 0, 0, 0);
    vectors++;
    if (out_valid !== 0) begin
      miscompares++;
      $display("FAIL flush_drop: got out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 6,
            $urandom_range(0, 39) == 0, $urandom_range(0, 99) == 0,
            $urandom, $urandom, $urandom);
      vectors++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        miscompares++;
        $display("FAIL rand_hs[%0d]: got v=%b rdy=%b expected occupancy %0d", i,
                 out_valid, in_ready, q.size());
      end
      if (q.size() > 0) begin
        vectors++;
        if (got !== q[0]) begin
          miscompares++;
          $display("FAIL rand_entry[%0d]: got %h expected %h (instr %h)", i, got, q[0], instr);
        end
      end
    end
    rst = 1'b0;
    flush = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
